stage_sequencer: RTL and testbench

- Parametrised successor to the fixed init→KSA→decrypt test controller.
- Runs NUM_STAGES sub-FSMs strictly in order, one start/finish handshake per stage.
- Adds early exit on a per-stage fail flag, a per-stage watchdog timeout, and an abort input.
- Drives the memory-mux select, then holds a coded result until the cracking FSM acknowledges it.

---
 rtl/stage_sequencer_if.sv | 27 ++
 rtl/stage_sequencer.sv | 98 +++++++++
 tb/tb_stage_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: handshake bundle between stage_sequencer, its sub-FSMs and the cracking FSM.
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int SEL_W = $clog2(NUM_STAGES + 1)
);
    logic                  start;
    logic                  abort;
    logic                  ack;
    logic [NUM_STAGES-1:0] stage_finish;
    logic [NUM_STAGES-1:0] stage_fail;
    logic [NUM_STAGES-1:0] stage_start;
    logic [SEL_W-1:0]      active_sel;
    logic                  busy;
    logic                  finish;
    logic [1:0]            result_code;
    logic [5:0]            fail_stage;
    logic [7:0]            state_debug;
    logic [31:0]           cycle_count;
    modport master (
        input  start, abort, ack, stage_finish, stage_fail,
        output stage_start, active_sel, busy, finish, result_code, fail_stage, state_debug, cycle_count
    );
    modport slave (
        output start, abort, ack, stage_finish, stage_fail,
        input  stage_start, active_sel, busy, finish, result_code, fail_stage, state_debug, cycle_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: runs NUM_STAGES sub-FSMs in order with fail, watchdog and abort exits.
// Optional SEQ_CYCLE_COUNT_EN adds a saturating run-length counter on cycle_count.
module stage_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SEL_W = $clog2(NUM_STAGES + 1)
) (
    input logic clk,
    input logic nreset,
    stage_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, LAUNCH = 2'b01, WAIT = 2'b10, DONE = 2'b11} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] LAST = 6'(NUM_STAGES - 1);
    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d, fail_stage_q, fail_stage_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  result_q, result_d;
    logic        fin, fail, to, busy_q;
    assign fin    = |(bus.stage_finish & (NUM_STAGES'(1) << idx_q));
    assign fail   = |(bus.stage_fail & (NUM_STAGES'(1) << idx_q));
    assign to     = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    assign busy_q = (state_q == LAUNCH) || (state_q == WAIT);
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            fail_stage_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            fail_stage_q <= fail_stage_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        fail_stage_d = fail_stage_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d      = LAUNCH;
                idx_d        = '0;
                result_d     = 2'b00;
                fail_stage_d = '0;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = bus.abort ? IDLE : WAIT;
            end
            WAIT: if (bus.abort) state_d = IDLE;
            else if (fin && fail) begin
                state_d      = DONE;
                result_d     = 2'b10;
                fail_stage_d = idx_q;
            end else if (fin && idx_q == LAST) begin
                state_d  = DONE;
                result_d = 2'b01;
            end else if (fin) begin
                state_d = LAUNCH;
                idx_d   = idx_q + 6'd1;
            end else if (to) begin
                state_d      = DONE;
                result_d     = 2'b11;
                fail_stage_d = idx_q;
            end else cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
            DONE: if (bus.ack) state_d = IDLE;
        endcase
    end
`ifdef SEQ_CYCLE_COUNT_EN
    logic [31:0] cc_q, cc_d;
    // the start-sample cycle counts as the first, so a zero-wait run reads 2*NUM_STAGES+1
    assign cc_d = (state_q == IDLE && bus.start) ? 32'd1 : (busy_q && !(&cc_q)) ? cc_q + 32'd1 : cc_q;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) cc_q <= '0;
        else cc_q <= cc_d;
    end
`endif
    always_comb begin
        bus.stage_start = (state_q == LAUNCH) ? NUM_STAGES'(1) << idx_q : '0;
        bus.active_sel  = busy_q ? SEL_W'(idx_q) : SEL_W'(NUM_STAGES);
        bus.busy        = busy_q;
        bus.finish      = state_q == DONE;
        bus.result_code = result_q;
        bus.fail_stage  = fail_stage_q;
        bus.state_debug = {idx_q, state_q};
`ifdef SEQ_CYCLE_COUNT_EN
        bus.cycle_count = cc_q;
`else
        bus.cycle_count = '0;
`endif
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: table-driven vectors plus directed sequences for timeout, latency and reset.
module tb_stage_sequencer;
    logic clk = 1'b0;
    logic nreset;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    stage_sequencer_if #(.NUM_STAGES(3), .SEL_W(2)) bus ();
    stage_sequencer #(.NUM_STAGES(3), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus)
    );
    typedef struct {
        logic       st, ab, ak;
        logic [2:0] fin, fl, ss;
        logic [1:0] sel;
        logic       bz, dn;
        logic [1:0] rc;
        logic [5:0] fs;
        logic [7:0] dbg;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(logic st, logic ab, logic ak, logic [2:0] fin, logic [2:0] fl, logic [2:0] ss,
                                logic [1:0] sel, logic bz, logic dn, logic [1:0] rc, logic [5:0] fs, logic [7:0] dbg);
        vec_t v;
        v.st = st; v.ab = ab; v.ak = ak; v.fin = fin; v.fl = fl; v.ss = ss;
        v.sel = sel; v.bz = bz; v.dn = dn; v.rc = rc; v.fs = fs; v.dbg = dbg;
        return v;
    endfunction
    function automatic logic [22:0] snap();
        return {bus.stage_start, bus.active_sel, bus.busy, bus.finish, bus.result_code, bus.fail_stage, bus.state_debug};
    endfunction
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic st, input logic ab, input logic ak, input logic [2:0] fin, input logic [2:0] fl);
        bus.start = st; bus.abort = ab; bus.ack = ak; bus.stage_finish = fin; bus.stage_fail = fl;
    endtask
    task automatic to_stage2_wait();
        drive(1, 0, 0, 3'b000, 3'b000); step();
        drive(0, 0, 0, 3'b000, 3'b000); step();
        drive(0, 0, 0, 3'b001, 3'b000); step();
        drive(0, 0, 0, 3'b000, 3'b000); step();
        drive(0, 0, 0, 3'b010, 3'b000); step();
        drive(0, 0, 0, 3'b000, 3'b000); step();
        chk("reach_wait2", 32'(bus.state_debug), 32'h0A);
    endtask
    localparam logic [22:0] IDLE_SNAP = {3'b000, 2'd3, 1'b0, 1'b0, 2'b00, 6'd0, 8'h00};
    initial begin
        int n;
        logic [31:0] cc;
        // clean pass with fin 3 cycles after each pulse, plus stray finish bits, DONE hold and re-start
        tbl.push_back(mk(1,0,0,3'd0,3'd0, 3'd1,2'd0,1,0,2'd0,6'd0,8'h01));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd0,1,0,2'd0,6'd0,8'h02));
        tbl.push_back(mk(0,0,0,3'd4,3'd4, 3'd0,2'd0,1,0,2'd0,6'd0,8'h02));
        tbl.push_back(mk(0,0,0,3'd1,3'd0, 3'd2,2'd1,1,0,2'd0,6'd0,8'h05));
        tbl.push_back(mk(0,0,0,3'd2,3'd0, 3'd0,2'd1,1,0,2'd0,6'd0,8'h06));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd1,1,0,2'd0,6'd0,8'h06));
        tbl.push_back(mk(0,0,0,3'd2,3'd0, 3'd4,2'd2,1,0,2'd0,6'd0,8'h09));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd2,1,0,2'd0,6'd0,8'h0A));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd2,1,0,2'd0,6'd0,8'h0A));
        tbl.push_back(mk(0,0,0,3'd4,3'd0, 3'd0,2'd3,0,1,2'd1,6'd0,8'h0B));
        tbl.push_back(mk(0,1,0,3'd0,3'd0, 3'd0,2'd3,0,1,2'd1,6'd0,8'h0B));
        tbl.push_back(mk(1,0,0,3'd0,3'd0, 3'd0,2'd3,0,1,2'd1,6'd0,8'h0B));
        tbl.push_back(mk(1,0,1,3'd0,3'd0, 3'd0,2'd3,0,0,2'd1,6'd0,8'h08));
        tbl.push_back(mk(1,0,0,3'd0,3'd0, 3'd1,2'd0,1,0,2'd0,6'd0,8'h01));
        // early fail on stage 1
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd0,1,0,2'd0,6'd0,8'h02));
        tbl.push_back(mk(0,0,0,3'd1,3'd0, 3'd2,2'd1,1,0,2'd0,6'd0,8'h05));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd1,1,0,2'd0,6'd0,8'h06));
        tbl.push_back(mk(0,0,0,3'd2,3'd2, 3'd0,2'd3,0,1,2'd2,6'd1,8'h07));
        tbl.push_back(mk(0,0,1,3'd0,3'd0, 3'd0,2'd3,0,0,2'd2,6'd1,8'h04));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd3,0,0,2'd2,6'd1,8'h04));
        // abort in WAIT of stage 1, in LAUNCH, and abort beating finish
        tbl.push_back(mk(1,0,0,3'd0,3'd0, 3'd1,2'd0,1,0,2'd0,6'd0,8'h01));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd0,1,0,2'd0,6'd0,8'h02));
        tbl.push_back(mk(0,0,0,3'd1,3'd0, 3'd2,2'd1,1,0,2'd0,6'd0,8'h05));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd1,1,0,2'd0,6'd0,8'h06));
        tbl.push_back(mk(0,1,0,3'd0,3'd0, 3'd0,2'd3,0,0,2'd0,6'd0,8'h04));
        tbl.push_back(mk(1,0,0,3'd0,3'd0, 3'd1,2'd0,1,0,2'd0,6'd0,8'h01));
        tbl.push_back(mk(0,1,0,3'd0,3'd0, 3'd0,2'd3,0,0,2'd0,6'd0,8'h00));
        tbl.push_back(mk(1,0,0,3'd0,3'd0, 3'd1,2'd0,1,0,2'd0,6'd0,8'h01));
        tbl.push_back(mk(0,0,0,3'd0,3'd0, 3'd0,2'd0,1,0,2'd0,6'd0,8'h02));
        tbl.push_back(mk(0,1,0,3'd1,3'd0, 3'd0,2'd3,0,0,2'd0,6'd0,8'h00));
        drive(0, 0, 0, 3'b000, 3'b000);
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(snap()), 32'(IDLE_SNAP));
        chk("reset_cycle_count", bus.cycle_count, 32'd0);
        nreset = 1'b1;
        step();
        chk("release_no_pulse", 32'(snap()), 32'(IDLE_SNAP));
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].ak, tbl[i].fin, tbl[i].fl);
            step();
            chk($sformatf("row%0d", i), 32'(snap()),
                32'({tbl[i].ss, tbl[i].sel, tbl[i].bz, tbl[i].dn, tbl[i].rc, tbl[i].fs, tbl[i].dbg}));
        end
        drive(0, 0, 0, 3'b000, 3'b000);
        step();
        to_stage2_wait();
        n = 0;
        while (bus.state_debug[1:0] == 2'b10 && n < 100) begin
            n++;
            step();
        end
        chk("timeout_wait_cycles", 32'(n), 32'd16);
        chk("timeout_result", 32'(bus.result_code), 32'd3);
        chk("timeout_fail_stage", 32'(bus.fail_stage), 32'd2);
        chk("timeout_finish", 32'(bus.finish), 32'd1);
        drive(0, 0, 1, 3'b000, 3'b000); step();
        drive(0, 0, 0, 3'b000, 3'b000); step();
        to_stage2_wait();
        repeat (15) step();
        chk("edge_still_wait", 32'(bus.state_debug), 32'h0A);
        drive(0, 0, 0, 3'b100, 3'b000); step();
        chk("finish_beats_timeout", 32'(bus.result_code), 32'd1);
        chk("finish_beats_timeout_fs", 32'(bus.fail_stage), 32'd0);
        drive(0, 0, 1, 3'b000, 3'b000); step();
        drive(1, 0, 0, 3'b111, 3'b000); step();
        bus.start = 1'b0;
        n = 1;
        while (!bus.finish && n < 50) begin
            step();
            n++;
        end
        chk("zero_wait_latency", 32'(n), 32'd7);
        chk("zero_wait_result", 32'(bus.result_code), 32'd1);
`ifdef SEQ_CYCLE_COUNT_EN
        chk("cycle_count_done", bus.cycle_count, 32'd7);
`else
        chk("cycle_count_tied", bus.cycle_count, 32'd0);
`endif
        cc = bus.cycle_count;
        repeat (2) step();
        chk("cycle_count_hold_done", bus.cycle_count, cc);
        drive(0, 0, 1, 3'b000, 3'b000); step();
        drive(0, 0, 0, 3'b000, 3'b000); step();
        chk("cycle_count_hold_idle", bus.cycle_count, cc);
        drive(1, 0, 0, 3'b000, 3'b000); step();
        drive(0, 0, 0, 3'b000, 3'b000); step();
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #3 nreset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(snap()), 32'(IDLE_SNAP));
        chk("async_reset_cycle_count", bus.cycle_count, 32'd0);
        step();
        nreset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_reset_idle%0d", k), 32'(snap()), 32'(IDLE_SNAP));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
